// File: rtl/butterfly_r2_pipe_pkg.sv
// Shared helpers for the radix-2 butterfly: Q-format constants,
// complex field access, rounding shift and saturation.
package bfly_pkg;

  localparam int DW_DEF = 16;
  localparam int TW_DEF = 16;

  typedef logic signed [63:0] wide_t;

  function automatic wide_t smax(input int w);
    return (wide_t'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic wide_t smin(input int w);
    return -(wide_t'(1) <<< (w - 1));
  endfunction

  // +1 and -1 in signed Q1.(TW-1)
  function automatic wide_t tw_one(input int tw);
    return smax(tw);
  endfunction

  function automatic wide_t tw_minus_one(input int tw);
    return smin(tw);
  endfunction

  function automatic wide_t sext(input logic [63:0] v,
                                 input int w);
    wide_t t;
    t = wide_t'(v << (64 - w));
    return t >>> (64 - w);
  endfunction

  // {re, im} with re in the upper half
  function automatic wide_t cpx_re(input logic [127:0] c,
                                   input int w);
    return sext(64'(c >> w), w);
  endfunction

  function automatic wide_t cpx_im(input logic [127:0] c,
                                   input int w);
    return sext(c[63:0], w);
  endfunction

  // round half-up, then arithmetic shift
  function automatic wide_t round_shift(input wide_t x,
                                        input int sh);
    return (x + (wide_t'(1) <<< (sh - 1))) >>> sh;
  endfunction

  function automatic wide_t sat(input wide_t x, input int w);
    if (x > smax(w)) return smax(w);
    if (x < smin(w)) return smin(w);
    return x;
  endfunction

  function automatic logic sat_hit(input wide_t x, input int w);
    return (x > smax(w)) || (x < smin(w));
  endfunction

endpackage

// File: rtl/butterfly_r2_pipe_if.sv
// Butterfly stream bundle: input side (a, b, tf, in_inv[, in_scale])
// with valid/ready, output side (y, z) with valid/ready.
// in_scale exists only when BFLY_SCALE_EN is defined.
interface butterfly_r2_pipe_if #(
  parameter int DW = 16,
  parameter int TW = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] a;
  logic [2*DW-1:0] b;
  logic [2*TW-1:0] tf;
  logic            in_inv;
`ifdef BFLY_SCALE_EN
  logic            in_scale;
`endif
  logic            out_valid;
  logic            out_ready;
  logic [2*DW-1:0] y;
  logic [2*DW-1:0] z;

  modport master (
    output in_valid, a, b, tf, in_inv,
`ifdef BFLY_SCALE_EN
    output in_scale,
`endif
    input  in_ready,
    input  out_valid, y, z,
    output out_ready
  );

  modport slave (
    input  in_valid, a, b, tf, in_inv,
`ifdef BFLY_SCALE_EN
    input  in_scale,
`endif
    output in_ready,
    output out_valid, y, z,
    input  out_ready
  );
endinterface

// File: rtl/butterfly_r2_pipe_cmul_pipe.sv
// Stages S1-S2: optional twiddle conjugation, four products, then
// combine and round to DW+1 bits. side carries a/scale alongside.
// Ports: clock, reset, adv (global advance), in_valid, b, tf, inv,
// side_in -> out_valid, pr, pj, side_out.
module cmul_pipe
  import bfly_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF,
  parameter int SW = 2 * DW_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               adv,
  input  logic               in_valid,
  input  logic [2*DW-1:0]    b,
  input  logic [2*TW-1:0]    tf,
  input  logic               inv,
  input  logic [SW-1:0]      side_in,
  output logic               out_valid,
  output logic signed [DW:0] pr,
  output logic signed [DW:0] pj,
  output logic [SW-1:0]      side_out
);
  localparam int PW = DW + TW;
  localparam logic signed [TW-1:0] T_MAX =
    TW'(tw_one(TW));
  localparam logic signed [TW-1:0] T_MIN =
    TW'(tw_minus_one(TW));

  logic signed [DW-1:0] br, bj;
  logic signed [TW-1:0] tr, tj, tjc;

  assign br = b[2*DW-1:DW];
  assign bj = b[DW-1:0];
  assign tr = tf[2*TW-1:TW];
  assign tj = tf[TW-1:0];

  // -(-1) is not representable; clamp to +1
  always_comb begin
    tjc = tj;
    if (inv) tjc = (tj == T_MIN) ? T_MAX : -tj;
  end

  logic                 v1;
  logic signed [PW-1:0] m_rr, m_jj, m_rj, m_jr;
  logic [SW-1:0]        side1;

  always_ff @(posedge clock) begin
    if (reset) begin
      v1        <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      v1        <= in_valid;
      out_valid <= v1;
    end
  end

  always_ff @(posedge clock) begin
    if (adv && in_valid) begin
      m_rr  <= PW'(br) * PW'(tr);
      m_jj  <= PW'(bj) * PW'(tjc);
      m_rj  <= PW'(br) * PW'(tjc);
      m_jr  <= PW'(bj) * PW'(tr);
      side1 <= side_in;
    end
    if (adv && v1) begin
      pr <= (DW+1)'(round_shift(
              wide_t'(m_rr) - wide_t'(m_jj), TW - 1));
      pj <= (DW+1)'(round_shift(
              wide_t'(m_rj) + wide_t'(m_jr), TW - 1));
      side_out <= side1;
    end
  end
endmodule

// File: rtl/butterfly_r2_pipe.sv
// Radix-2 DIT butterfly, 3 stages: y = a + b*W, z = a - b*W.
// Ports: clock, reset, bus (slave stream), ovf (sticky), clr_ovf.
// BFLY_SCALE_EN: per-sample halving of the S3 result via in_scale.
module butterfly_r2_pipe
  import bfly_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  butterfly_r2_pipe_if.slave   bus,
  output logic                 ovf,
  input  logic                 clr_ovf
);
`ifdef BFLY_SCALE_EN
  localparam int SW = 2 * DW + 1;
`else
  localparam int SW = 2 * DW;
`endif

  logic                 adv;
  logic                 v2, v3;
  logic signed [DW:0]   pr, pj;
  logic [SW-1:0]        side_in, side2;
  logic [2*DW-1:0]      y_q, z_q;

  // every stage moves together; no bubble squeeze
  assign adv          = !v3 || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = v3;
  assign bus.y        = y_q;
  assign bus.z        = z_q;

`ifdef BFLY_SCALE_EN
  assign side_in = {bus.in_scale, bus.a};
`else
  assign side_in = bus.a;
`endif

  cmul_pipe #(.DW(DW), .TW(TW), .SW(SW)) u_cmul (
    .clock     (clock),
    .reset     (reset),
    .adv       (adv),
    .in_valid  (bus.in_valid),
    .b         (bus.b),
    .tf        (bus.tf),
    .inv       (bus.in_inv),
    .side_in   (side_in),
    .out_valid (v2),
    .pr        (pr),
    .pj        (pj),
    .side_out  (side2)
  );

  logic scale;
  wide_t a_re, a_im;

  assign a_re = cpx_re(128'(side2[2*DW-1:0]), DW);
  assign a_im = cpx_im(128'(side2[2*DW-1:0]), DW);
`ifdef BFLY_SCALE_EN
  assign scale = side2[2*DW];
`else
  assign scale = 1'b0;
`endif

  wide_t           s [4];
  wide_t           t [4];
  logic [DW-1:0]   q [4];
  logic [3:0]      hit;

  always_comb begin
    s[0] = a_re + wide_t'(pr);
    s[1] = a_im + wide_t'(pj);
    s[2] = a_re - wide_t'(pr);
    s[3] = a_im - wide_t'(pj);
    hit  = '0;
    for (int i = 0; i < 4; i++) begin
      t[i]   = scale ? round_shift(s[i], 1) : s[i];
      q[i]   = DW'(sat(t[i], DW));
      hit[i] = sat_hit(t[i], DW);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v3  <= 1'b0;
      y_q <= '0;
      z_q <= '0;
      ovf <= 1'b0;
    end else begin
      if (adv) begin
        v3 <= v2;
        if (v2) begin
          y_q <= {q[0], q[1]};
          z_q <= {q[2], q[3]};
        end
      end
      // a saturation in the same cycle beats the clear
      if (clr_ovf) ovf <= 1'b0;
      if (adv && v2 && |hit) ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// Scoreboard bench for butterfly_r2_pipe (DW=TW=16): directed
// vectors, random streams with backpressure, mid-stream reset.
module tb_butterfly_r2_pipe;
  localparam int DW = 16;
  localparam int TW = 16;

  typedef struct {
    logic [31:0] y;
    logic [31:0] z;
    int          acc;
    bit          lat;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clr_ovf = 1'b0;
  logic ovf;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t sbq[$];
  bit   rnd_ready = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  butterfly_r2_pipe_if #(.DW(DW), .TW(TW)) bif();

  butterfly_r2_pipe #(.DW(DW), .TW(TW)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bif),
    .ovf     (ovf),
    .clr_ovf (clr_ovf)
  );

  function automatic logic [31:0] pk(input int re, input int im);
    return {16'(re), 16'(im)};
  endfunction

  function automatic longint clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // y = a + b*W, z = a - b*W with Q15 twiddle, round half-up
  function automatic void model(
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] tf, input bit inv, input bit sc,
    output logic [31:0] y, output logic [31:0] z);
    longint ar, ai, br, bi, tr, ti, pr, pj;
    longint r[4];
    ar = longint'($signed(a[31:16]));
    ai = longint'($signed(a[15:0]));
    br = longint'($signed(b[31:16]));
    bi = longint'($signed(b[15:0]));
    tr = longint'($signed(tf[31:16]));
    ti = longint'($signed(tf[15:0]));
    if (inv) ti = (ti == -32768) ? 32767 : -ti;
    pr = (br * tr - bi * ti + 16384) >>> 15;
    pj = (br * ti + bi * tr + 16384) >>> 15;
    r[0] = ar + pr;
    r[1] = ai + pj;
    r[2] = ar - pr;
    r[3] = ai - pj;
    for (int i = 0; i < 4; i++) begin
      if (sc) r[i] = (r[i] + 1) >>> 1;
      r[i] = clamp16(r[i]);
    end
    y = {16'(r[0]), 16'(r[1])};
    z = {16'(r[2]), 16'(r[3])};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // caller sits just after a rising edge; returns likewise
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] tf, input bit inv,
                      input bit sc, input logic [31:0] ey,
                      input logic [31:0] ez, input bit lat);
    exp_t e;
    int n;
    n = 0;
    bif.a = a;
    bif.b = b;
    bif.tf = tf;
    bif.in_inv = inv;
`ifdef BFLY_SCALE_EN
    bif.in_scale = sc;
`endif
    bif.in_valid = 1'b1;
    e.y = ey;
    e.z = ez;
    e.lat = lat;
    forever begin
      @(negedge clock);
      if (bif.in_ready) begin
        e.acc = cyc;
        sbq.push_back(e);
        @(posedge clock);
        #1;
        break;
      end
      @(posedge clock);
      #1;
      n++;
      if (n > 50) begin
        checks++;
        $display("FAIL send_timeout: in_ready low %0d cycles", n);
        break;
      end
    end
  endtask

  task automatic send_rand();
    logic [31:0] a, b, tf, ey, ez;
    bit inv, sc, sce;
    a = $urandom;
    b = $urandom;
    tf = $urandom;
    inv = 1'($urandom_range(0, 1));
    sc = 1'($urandom_range(0, 1));
    sce = sc;
`ifndef BFLY_SCALE_EN
    sce = 1'b0;
`endif
    model(a, b, tf, inv, sce, ey, ez);
    send(a, b, tf, inv, sc, ey, ez, 1'b0);
  endtask

  task automatic idle(input int n);
    bif.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // monitor: pops on every output transfer
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        chk("in_ready", 64'(bif.in_ready),
            64'(!bif.out_valid || bif.out_ready));
        if (bif.out_valid && bif.out_ready) begin
          if (sbq.size() == 0) begin
            checks++;
            $display("FAIL unexpected_out: y=%h z=%h, none queued",
                     bif.y, bif.z);
          end else begin
            e = sbq.pop_front();
            chk("y", 64'(bif.y), 64'(e.y));
            chk("z", 64'(bif.z), 64'(e.z));
            if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd3);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] a1, b1, t1, tmj, ey, ez;
    bif.in_valid = 1'b0;
    bif.a = '0;
    bif.b = '0;
    bif.tf = '0;
    bif.in_inv = 1'b0;
`ifdef BFLY_SCALE_EN
    bif.in_scale = 1'b0;
`endif
    bif.out_ready = 1'b1;
    a1 = pk(100, -50);
    b1 = pk(200, 30);
    t1 = pk(32767, 0);
    tmj = pk(0, -32768);

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_out_valid", 64'(bif.out_valid), 64'd0);
    chk("rst_y", 64'(bif.y), 64'd0);
    chk("rst_z", 64'(bif.z), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    send(a1, b1, t1, 1'b0, 1'b0,
         pk(300, -20), pk(-100, -80), 1'b1);
    send(a1, b1, tmj, 1'b0, 1'b0,
         pk(130, -250), pk(70, 150), 1'b1);
    send(a1, b1, tmj, 1'b1, 1'b0,
         pk(70, 150), pk(130, -250), 1'b1);
`ifdef BFLY_SCALE_EN
    send(a1, b1, t1, 1'b0, 1'b1,
         pk(150, -10), pk(-50, -40), 1'b1);
`else
    send(a1, b1, t1, 1'b0, 1'b1,
         pk(300, -20), pk(-100, -80), 1'b1);
`endif
    idle(6);
    @(negedge clock);
    chk("ovf_clean", 64'(ovf), 64'd0);
    @(posedge clock);
    #1;

    send(pk(32000, 0), pk(32000, 0), t1, 1'b0, 1'b0,
         pk(32767, 0), pk(1, 0), 1'b1);
    idle(5);
    @(negedge clock);
    chk("ovf_set", 64'(ovf), 64'd1);
    @(posedge clock);
    #1;
    clr_ovf = 1'b1;
    @(posedge clock);
    #1;
    clr_ovf = 1'b0;
    @(negedge clock);
    chk("ovf_clr", 64'(ovf), 64'd0);
    @(posedge clock);
    #1;

    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
        bif.in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clock);
        #1;
        bif.out_ready = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        bif.out_ready = 1'b1;
      end
    join
    idle(10);
    chk("bp_drained", 64'(sbq.size()), 64'd0);

    rnd_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send_rand();
          if ($urandom_range(0, 3) == 0)
            idle($urandom_range(1, 3));
        end
        bif.in_valid = 1'b0;
        rnd_ready = 1'b0;
      end
      begin
        while (rnd_ready) begin
          @(posedge clock);
          #1;
          bif.out_ready = ($urandom_range(0, 2) != 0);
        end
        bif.out_ready = 1'b1;
      end
    join
    idle(12);
    chk("rnd_drained", 64'(sbq.size()), 64'd0);

    bif.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_rand();
    bif.in_valid = 1'b0;
    reset = 1'b1;
    sbq.delete();
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("mid_rst_valid", 64'(bif.out_valid), 64'd0);
    chk("mid_rst_y", 64'(bif.y), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    bif.out_ready = 1'b1;
    idle(8);
    chk("mid_rst_empty", 64'(sbq.size()), 64'd0);

    model(a1, b1, tmj, 1'b1, 1'b0, ey, ez);
    send(a1, b1, tmj, 1'b1, 1'b0, ey, ez, 1'b1);
    idle(6);
    chk("final_drained", 64'(sbq.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end
endmodule
